pipe_hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage RV32I core. Generates PC/IF-ID/ID-EX stall and flush controls.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 47 ++++
 rtl/pipe_hazard_ctrl_md_watchdog.sv | 60 ++++++
 rtl/pipe_hazard_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the RV32I pipeline hazard controller: the FSM state
// encoding, the bundle of pipeline-register controls, and small helpers
// used by the hazard comparator.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN    = 2'd0,
        CTRL_LDUSE  = 2'd1,
        CTRL_MDWAIT = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_flush;
    } pipe_ctrl_t;

    // No action: every pipeline register advances normally.
    localparam pipe_ctrl_t PIPE_CTRL_NONE = '{
        pc_stall: 1'b0, if_id_stall: 1'b0, if_id_flush: 1'b0,
        id_ex_stall: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0};

    // Load-use bubble: freeze fetch/decode, inject a NOP into EX.
    localparam pipe_ctrl_t PIPE_CTRL_LDUSE = '{
        pc_stall: 1'b1, if_id_stall: 1'b1, if_id_flush: 1'b0,
        id_ex_stall: 1'b0, id_ex_flush: 1'b1, ex_mem_flush: 1'b0};

    // Taken redirect from EX: squash the two younger instructions.
    localparam pipe_ctrl_t PIPE_CTRL_BRANCH = '{
        pc_stall: 1'b0, if_id_stall: 1'b0, if_id_flush: 1'b1,
        id_ex_stall: 1'b0, id_ex_flush: 1'b1, ex_mem_flush: 1'b0};

    // Multi-cycle EX op in flight: hold everything upstream, bubble into MEM.
    localparam pipe_ctrl_t PIPE_CTRL_MDWAIT = '{
        pc_stall: 1'b1, if_id_stall: 1'b1, if_id_flush: 1'b0,
        id_ex_stall: 1'b1, id_ex_flush: 1'b0, ex_mem_flush: 1'b1};

    // One source operand of the ID instruction depends on the EX destination.
    function automatic logic src_matches(input logic [4:0] rs, input logic used,
                                         input logic [4:0] rd);
        return used && (rs == rd);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_watchdog.sv
// md_watchdog: counts cycles spent waiting on a multi-cycle EX op and
// raises a registered one-cycle md_err pulse when the wait hits the limit.
// The timer starts at 1 on the cycle the wait is entered and saturates.
import pipe_hazard_ctrl_pkg::*;

module md_watchdog #(
    parameter int MD_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic arm_i,      // entering the wait this cycle
    input  logic wait_i,     // currently in the wait state
    input  logic done_i,     // multi-cycle result valid
    output logic expired_o,  // wait limit reached this cycle
    output logic md_err_o
);
    localparam int TW = $clog2(MD_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LIMIT = TW'(MD_TIMEOUT);
    localparam logic [TW-1:0] TIMER_MAX   = {TW{1'b1}};

    logic [TW-1:0] timer_q, timer_d;
    logic          md_err_q, md_err_d;

    assign expired_o = wait_i && (timer_q == TIMER_LIMIT);
    assign md_err_o  = md_err_q;

    // Timer next value: load on arm, count while waiting, clear otherwise.
    always_comb begin
        timer_d  = timer_q;
        md_err_d = 1'b0;
        if (arm_i) begin
            timer_d = TW'(1);
        end else if (wait_i) begin
            if (done_i) begin
                timer_d = '0;
            end else if (expired_o) begin
                timer_d  = '0;
                md_err_d = 1'b1;
            end else if (timer_q != TIMER_MAX) begin
                timer_d = timer_q + TW'(1);
            end else begin
                timer_d = timer_q;
            end
        end else begin
            timer_d = '0;
        end
    end

    // Timer and error pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q  <= '0;
            md_err_q <= 1'b0;
        end else begin
            timer_q  <= timer_d;
            md_err_q <= md_err_d;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencing for the 5-stage RV32I pipeline.
// Resolves load-use hazards, taken EX redirects and multi-cycle EX ops.
// Pipeline controls are combinational from state and inputs; ctrl_state
// and md_err are registered.
// Optional build macro PIPE_HAZARD_PERF_EN adds stall/flush perf counters.
import pipe_hazard_ctrl_pkg::*;

module pipe_hazard_ctrl #(
    parameter int LDUSE_BUBBLES = 1,
    parameter int MD_TIMEOUT    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_rs1_used_i,
    input  logic       id_rs2_used_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_mem_read_i,
    input  logic       ex_branch_taken_i,
    input  logic       md_start_i,
    input  logic       md_done_i,
    output logic       pc_stall_o,
    output logic       if_id_stall_o,
    output logic       if_id_flush_o,
    output logic       id_ex_stall_o,
    output logic       id_ex_flush_o,
    output logic       ex_mem_flush_o,
    output logic       md_err_o,
    output logic [1:0] ctrl_state_o
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_flush_cnt_o
`endif
);
    localparam logic [1:0] LDUSE_RELOAD = 2'(LDUSE_BUBBLES - 1);

    ctrl_state_e state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        hz_s;
    logic        md_arm_s;
    logic        md_wait_s;
    logic        md_expired_s;
    pipe_ctrl_t  ctrl_s;

    // Load-use hazard: a load in EX writes a register the ID instruction reads.
    assign hz_s = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                  (src_matches(id_rs1_i, id_rs1_used_i, ex_rd_i) ||
                   src_matches(id_rs2_i, id_rs2_used_i, ex_rd_i));

    assign md_wait_s = (state_q == CTRL_MDWAIT);

    md_watchdog #(
        .MD_TIMEOUT (MD_TIMEOUT)
    ) u_md_watchdog (
        .clk       (clk),
        .rst       (rst),
        .arm_i     (md_arm_s),
        .wait_i    (md_wait_s),
        .done_i    (md_done_i),
        .expired_o (md_expired_s),
        .md_err_o  (md_err_o)
    );

    // FSM state and bubble counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CTRL_RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: branch beats multi-cycle op beats load-use in RUN.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_arm_s = 1'b0;
        case (state_q)
            CTRL_RUN: begin
                if (ex_branch_taken_i) begin
                    state_d = CTRL_RUN;
                end else if (md_start_i && !md_done_i) begin
                    state_d  = CTRL_MDWAIT;
                    md_arm_s = 1'b1;
                end else if (md_start_i) begin
                    state_d = CTRL_RUN;
                end else if (hz_s && (LDUSE_BUBBLES > 1)) begin
                    state_d = CTRL_LDUSE;
                    cnt_d   = LDUSE_RELOAD;
                end else begin
                    state_d = CTRL_RUN;
                end
            end
            CTRL_LDUSE: begin
                if (cnt_q <= 2'd1) begin
                    state_d = CTRL_RUN;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            CTRL_MDWAIT: begin
                if (md_done_i || md_expired_s) begin
                    state_d = CTRL_RUN;
                end else begin
                    state_d = CTRL_MDWAIT;
                end
            end
            default: begin
                state_d = CTRL_RUN;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // Pipeline controls: decoded from state and inputs, forced quiet in reset.
    always_comb begin
        ctrl_s = PIPE_CTRL_NONE;
        if (rst) begin
            ctrl_s = PIPE_CTRL_NONE;
        end else begin
            case (state_q)
                CTRL_RUN: begin
                    if (ex_branch_taken_i) begin
                        ctrl_s = PIPE_CTRL_BRANCH;
                    end else if (md_start_i && !md_done_i) begin
                        ctrl_s = PIPE_CTRL_MDWAIT;
                    end else if (md_start_i) begin
                        ctrl_s = PIPE_CTRL_NONE;
                    end else if (hz_s) begin
                        ctrl_s = PIPE_CTRL_LDUSE;
                    end else begin
                        ctrl_s = PIPE_CTRL_NONE;
                    end
                end
                CTRL_LDUSE: begin
                    ctrl_s = PIPE_CTRL_LDUSE;
                end
                CTRL_MDWAIT: begin
                    if (md_done_i || md_expired_s) begin
                        ctrl_s = PIPE_CTRL_NONE;
                    end else begin
                        ctrl_s = PIPE_CTRL_MDWAIT;
                    end
                end
                default: begin
                    ctrl_s = PIPE_CTRL_NONE;
                end
            endcase
        end
    end

    assign pc_stall_o     = ctrl_s.pc_stall;
    assign if_id_stall_o  = ctrl_s.if_id_stall;
    assign if_id_flush_o  = ctrl_s.if_id_flush;
    assign id_ex_stall_o  = ctrl_s.id_ex_stall;
    assign id_ex_flush_o  = ctrl_s.id_ex_flush;
    assign ex_mem_flush_o = ctrl_s.ex_mem_flush;
    assign ctrl_state_o   = state_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;
    logic        flush_evt_s;

    // A flush event is a taken redirect acted upon in RUN.
    assign flush_evt_s = (state_q == CTRL_RUN) && ex_branch_taken_i;

    // Free-running stall-cycle and branch-flush counters, wrapping mod 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_q + {31'd0, ctrl_s.pc_stall};
            perf_flush_q <= perf_flush_q + {31'd0, flush_evt_s};
        end
    end

    assign perf_stall_cnt_o = perf_stall_q;
    assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl. Two instances with different
// bubble counts and timeouts share one input stream; each is compared every
// cycle against a counter-based reference model of the sequencing rules.
module tb_pipe_hazard_ctrl;

    localparam int LB_A = 1;
    localparam int TO_A = 8;
    localparam int LB_B = 3;
    localparam int TO_B = 5;

    // Expected control bundles, bit order {pc_st, ifid_st, ifid_fl, idex_st, idex_fl, exmem_fl}
    localparam logic [5:0] EXP_NONE = 6'b000000;
    localparam logic [5:0] EXP_LD   = 6'b110010;
    localparam logic [5:0] EXP_BR   = 6'b001010;
    localparam logic [5:0] EXP_MD   = 6'b110101;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_mem_read;
    logic       ex_branch_taken, md_start, md_done;

    logic       a_pc, a_ifs, a_iff, a_ids, a_idf, a_exf, a_err;
    logic [1:0] a_st;
    logic       b_pc, b_ifs, b_iff, b_ids, b_idf, b_exf, b_err;
    logic [1:0] b_st;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] a_pstall, a_pflush, b_pstall, b_pflush;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state per instance
    int m_ld   [2];   // bubbles still owed after the current one
    bit m_md   [2];   // waiting on a multi-cycle op
    int m_age  [2];   // cycles spent waiting
    bit m_err  [2];   // md_err value visible this cycle
    int m_ps   [2];
    int m_pf   [2];
    int m_lb   [2];
    int m_to   [2];

    pipe_hazard_ctrl #(.LDUSE_BUBBLES(LB_A), .MD_TIMEOUT(TO_A)) u_dut_a (
        .clk(clk), .rst(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .ex_rd_i(ex_rd), .ex_mem_read_i(ex_mem_read),
        .ex_branch_taken_i(ex_branch_taken),
        .md_start_i(md_start), .md_done_i(md_done),
        .pc_stall_o(a_pc), .if_id_stall_o(a_ifs), .if_id_flush_o(a_iff),
        .id_ex_stall_o(a_ids), .id_ex_flush_o(a_idf), .ex_mem_flush_o(a_exf),
        .md_err_o(a_err), .ctrl_state_o(a_st)
`ifdef PIPE_HAZARD_PERF_EN
        , .perf_stall_cnt_o(a_pstall), .perf_flush_cnt_o(a_pflush)
`endif
    );

    pipe_hazard_ctrl #(.LDUSE_BUBBLES(LB_B), .MD_TIMEOUT(TO_B)) u_dut_b (
        .clk(clk), .rst(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .ex_rd_i(ex_rd), .ex_mem_read_i(ex_mem_read),
        .ex_branch_taken_i(ex_branch_taken),
        .md_start_i(md_start), .md_done_i(md_done),
        .pc_stall_o(b_pc), .if_id_stall_o(b_ifs), .if_id_flush_o(b_iff),
        .id_ex_stall_o(b_ids), .id_ex_flush_o(b_idf), .ex_mem_flush_o(b_exf),
        .md_err_o(b_err), .ctrl_state_o(b_st)
`ifdef PIPE_HAZARD_PERF_EN
        , .perf_stall_cnt_o(b_pstall), .perf_flush_cnt_o(b_pflush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit hazard();
        return ex_mem_read && (ex_rd != 5'd0) &&
               ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    endfunction

    task automatic model_reset(input int k);
        m_ld[k] = 0; m_md[k] = 0; m_age[k] = 0; m_err[k] = 0; m_ps[k] = 0; m_pf[k] = 0;
    endtask

    // Expected outputs for the current cycle, then advance the model one clock.
    task automatic model_step(input int k, output logic [5:0] ctl, output logic err,
                              output logic [1:0] st);
        bit nerr;
        nerr = 0;
        ctl  = EXP_NONE;
        err  = m_err[k];
        st   = (m_ld[k] > 0) ? 2'd1 : (m_md[k] ? 2'd2 : 2'd0);
        if (rst) begin
            err = 1'b0;
            st  = 2'd0;
            model_reset(k);
        end else if (m_ld[k] > 0) begin
            ctl = EXP_LD;
            m_ld[k]--;
        end else if (m_md[k]) begin
            if (md_done) begin
                m_md[k] = 0;
            end else if (m_age[k] == m_to[k]) begin
                m_md[k] = 0;
                nerr = 1;
            end else begin
                ctl = EXP_MD;
                m_age[k]++;
            end
        end else if (ex_branch_taken) begin
            ctl = EXP_BR;
            m_pf[k]++;
        end else if (md_start && !md_done) begin
            ctl = EXP_MD;
            m_md[k] = 1;
            m_age[k] = 1;
        end else if (md_start) begin
            ctl = EXP_NONE;
        end else if (hazard()) begin
            ctl = EXP_LD;
            m_ld[k] = m_lb[k] - 1;
        end
        if (!rst && ctl[5]) m_ps[k]++;
        m_err[k] = nerr;
    endtask

    // Compare both instances mid-cycle, then move to just after the next edge.
    task automatic run_cycle();
        logic [5:0] ec;
        logic       ee;
        logic [1:0] es;
        #1;
`ifdef PIPE_HAZARD_PERF_EN
        check_eq("A.perf_stall", a_pstall, 32'(m_ps[0]));
        check_eq("A.perf_flush", a_pflush, 32'(m_pf[0]));
        check_eq("B.perf_stall", b_pstall, 32'(m_ps[1]));
        check_eq("B.perf_flush", b_pflush, 32'(m_pf[1]));
`endif
        model_step(0, ec, ee, es);
        check_eq("A.ctl", {26'd0, a_pc, a_ifs, a_iff, a_ids, a_idf, a_exf}, {26'd0, ec});
        check_eq("A.md_err", {31'd0, a_err}, {31'd0, ee});
        check_eq("A.state", {30'd0, a_st}, {30'd0, es});
        model_step(1, ec, ee, es);
        check_eq("B.ctl", {26'd0, b_pc, b_ifs, b_iff, b_ids, b_idf, b_exf}, {26'd0, ec});
        check_eq("B.md_err", {31'd0, b_err}, {31'd0, ee});
        check_eq("B.state", {30'd0, b_st}, {30'd0, es});
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic mr,
                         input logic br, input logic ms, input logic md);
        id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        ex_rd = rd; ex_mem_read = mr; ex_branch_taken = br; md_start = ms; md_done = md;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            run_cycle();
        end
    endtask

    initial begin
        m_lb[0] = LB_A; m_to[0] = TO_A;
        m_lb[1] = LB_B; m_to[1] = TO_B;
        model_reset(0);
        model_reset(1);

        // Reset with a hazard present: everything must stay quiet
        rst = 1'b1;
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        run_cycle();
        run_cycle();
        rst = 1'b0;
        idle(2);

        // Load-use on rs1
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        run_cycle();
        idle(4);
        // x0 destination and unused rs2 match never stall
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_cycle();
        drive(5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        run_cycle();
        idle(3);
        // Load-use on rs2
        drive(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        run_cycle();
        idle(4);
        // Branch together with a hazard: branch wins
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        run_cycle();
        idle(4);
        // Multi-cycle op completing on its 5th cycle
        for (int i = 0; i < 5; i++) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, (i == 4));
            run_cycle();
        end
        idle(2);
        // Start and done in the same cycle
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        run_cycle();
        idle(2);
        // Timeout: done never arrives
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_cycle();
        idle(12);
        // Reset in the middle of a multi-cycle wait
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_cycle();
        idle(2);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(TO_A + 2);
        // Reset in the middle of a multi-bubble load-use sequence
        drive(5'd2, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        run_cycle();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(3);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 15) == 0));
            run_cycle();
        end
        rst = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
